// File: rtl/vd4_pkg.sv
// Shared constants and types for the vd4 ripple-carry adder.
package vd4_pkg;

   localparam int VD4_WIDTH_DEFAULT = 4;

   // {cout, s} result at the default width
   typedef logic [VD4_WIDTH_DEFAULT:0] vd4_sum_t;

endpackage

// File: rtl/vd4_fa.sv
// 1-bit full adder cell, the leaf of the vd4 ripple chain.
module vd4_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;

   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);

endmodule

// File: rtl/vd4_adder.sv
// Ripple-carry adder with a one-cycle registered copy and valid flag.
// Optional registered zero/signed-overflow flags under `define VD4_FLAGS_EN.
module vd4_adder
   import vd4_pkg::*;
#(
   parameter int WIDTH = VD4_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic [WIDTH-1:0] s_q,
   output logic             cout_q,
   output logic             out_valid
`ifdef VD4_FLAGS_EN
   ,
   output logic             zero_q,
   output logic             ovf_q
`endif
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] s_d;
   logic             cout_d;
   logic             out_valid_d;

   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      vd4_fa u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (carry[i]),
         .s  (s[i]),
         .co (carry[i+1])
      );
   end

   assign cout = carry[WIDTH];

   // Result holds when idle; only the valid flag follows in_valid every edge.
   always_comb begin
      s_d         = s_q;
      cout_d      = cout_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         s_d    = s;
         cout_d = cout;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q       <= '0;
         cout_q    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         s_q       <= s_d;
         cout_q    <= cout_d;
         out_valid <= out_valid_d;
      end
   end

`ifdef VD4_FLAGS_EN
   logic zero_d;
   logic ovf_d;

   always_comb begin
      zero_d = zero_q;
      ovf_d  = ovf_q;
      if (in_valid) begin
         zero_d = (s == '0);
         ovf_d  = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         zero_q <= zero_d;
         ovf_q  <= ovf_d;
      end
   end
`endif

endmodule

// File: tb/tb_vd4_adder.sv
// Scoreboard bench for vd4_adder: combinational sum, registered copy, hold and async reset.
module tb_vd4_adder;
   import vd4_pkg::*;

   typedef struct packed {
      vd4_sum_t sum;
      logic     z;
      logic     o;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [3:0] a, b;
   logic       cin;
   logic [3:0] s, s_q;
   logic       cout, cout_q, out_valid;
`ifdef VD4_FLAGS_EN
   logic       zero_q, ovf_q;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   exp_t held;

   vd4_adder #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .s         (s),
      .cout      (cout),
      .s_q       (s_q),
      .cout_q    (cout_q),
      .out_valid (out_valid)
`ifdef VD4_FLAGS_EN
      ,
      .zero_q    (zero_q),
      .ovf_q     (ovf_q)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [3:0] ta, input logic [3:0] tb_, input logic tc);
      exp_t e;
      e.sum = {1'b0, ta} + {1'b0, tb_} + {4'b0, tc};
      e.z   = (e.sum[3:0] == 4'h0);
      e.o   = (ta[3] == tb_[3]) && (e.sum[3] != ta[3]);
      return e;
   endfunction

   task automatic chk_reg(input exp_t e);
      chk("s_q", 32'(s_q), 32'(e.sum[3:0]));
      chk("cout_q", 32'(cout_q), 32'(e.sum[4]));
`ifdef VD4_FLAGS_EN
      chk("zero_q", 32'(zero_q), 32'(e.z));
      chk("ovf_q", 32'(ovf_q), 32'(e.o));
`endif
   endtask

   task automatic step(input logic [3:0] ta, input logic [3:0] tb_, input logic tc, input logic tv);
      exp_t e;
      @(negedge clk);
      a = ta; b = tb_; cin = tc; in_valid = tv;
      e = model(ta, tb_, tc);
      #5 chk("comb_sum", 32'({cout, s}), 32'(e.sum));
      if (tv) sb_q.push_back(e);
      @(posedge clk);
      #1 chk("out_valid", 32'(out_valid), 32'(tv));
      if (out_valid) begin
         chk("sb_depth", 32'(sb_q.size()), 32'd1);
         if (sb_q.size() > 0) begin
            held = sb_q.pop_front();
            chk_reg(held);
         end
      end else begin
         chk_reg(held);
      end
   endtask

   initial begin
      held = '0;
      rst = 1'b1; in_valid = 1'b0; a = 4'h3; b = 4'h2; cin = 1'b0;
      #3;
      chk("rst_s_q", 32'(s_q), 32'd0);
      chk("rst_cout_q", 32'(cout_q), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_comb", 32'({cout, s}), 32'd5);
      @(negedge clk);
      rst = 1'b0;

      step(4'hF, 4'h1, 1'b0, 1'b1);   // carry wrap
      step(4'hF, 4'hF, 1'b1, 1'b1);   // maximum inputs
      step(4'h3, 4'h4, 1'b1, 1'b1);
      step(4'h7, 4'h1, 1'b0, 1'b1);   // signed overflow
      step(4'h8, 4'h8, 1'b0, 1'b1);   // zero + overflow + carry
      step(4'h2, 4'h3, 1'b0, 1'b1);
      step(4'hA, 4'h6, 1'b1, 1'b0);   // hold 0x5 while s follows new inputs
      step(4'h1, 4'h1, 1'b0, 1'b0);
      step(4'h4, 4'h5, 1'b0, 1'b1);   // capture 0x9

      // Async reset between edges, then a capture attempted while rst is high
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      held = '0;
      chk("arst_s_q", 32'(s_q), 32'd0);
      chk("arst_cout_q", 32'(cout_q), 32'd0);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
`ifdef VD4_FLAGS_EN
      chk("arst_zero_q", 32'(zero_q), 32'd0);
      chk("arst_ovf_q", 32'(ovf_q), 32'd0);
`endif
      a = 4'h1; b = 4'h2; cin = 1'b1; in_valid = 1'b1;
      #3 chk("arst_comb", 32'({cout, s}), 32'd4);
      @(posedge clk);
      #1;
      chk("arst_hold_s_q", 32'(s_q), 32'd0);
      chk("arst_hold_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      end

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
